lsb_extract: RTL and testbench
==============================

LSB_EXTRACT -- requirements
Module: lsb_extract

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning pixel sample width in bits.
REQ-002 SHALL have parameter LEN_W, default 8, meaning message-length counter width in bytes.
REQ-003 SHALL have port wb_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port wb_rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, begin an extraction; sampled only in IDLE.
REQ-006 SHALL have port msg_len, input, LEN_W, number of message bytes to extract; latched on accepted start.
REQ-007 SHALL have port key, input, 8, initial decryption key; latched on accepted start.
REQ-008 SHALL have port pix_data, input, PIX_W, stego pixel sample; only bit 0 is used.
REQ-009 SHALL have port pix_valid, input, 1, pix_data is valid.
REQ-010 SHALL have port pix_ready, output, 1, block accepts a pixel this cycle.
REQ-011 SHALL have port msg_byte, output, 8, decrypted message byte.
REQ-012 SHALL have port msg_valid, output, 1, msg_byte is valid.
REQ-013 SHALL have port msg_ready, input, 1, consumer accepts msg_byte.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at the end of a message.
REQ-016 SHALL have port checksum, output, 8, XOR of all decrypted bytes of the current or last message.

Function
REQ-017 SHALL implement the FSM states IDLE, COLLECT, EMIT and DONE.
REQ-018 SHALL, in IDLE with start=1, latch msg_len and key, clear byte_cnt, bit_cnt and checksum, and go to COLLECT (or to DONE if msg_len=0).
REQ-019 SHALL drive pix_ready=1 only in COLLECT; a pixel transfer is pix_valid & pix_ready.
REQ-020 SHALL, on each transfer, shift pix_data[0] into an 8-bit shift register MSB-first (first pixel -> bit 7) and increment the 3-bit bit_cnt.
REQ-021 SHALL, on the transfer with bit_cnt=7, register msg_byte = assembled byte XOR key_cur and enter EMIT, so msg_valid rises exactly one cycle after the 8th pixel.
REQ-022 SHALL, in EMIT, hold msg_valid=1 and msg_byte stable and keep pix_ready=0 until msg_ready=1 (backpressure stalls pixel intake).
REQ-023 SHALL, on msg_valid & msg_ready: XOR msg_byte into checksum, rotate key_cur left by 1, and increment byte_cnt.
REQ-024 SHALL, after that handshake, go to DONE if the handshake completed byte msg_len, else return to COLLECT.
REQ-025 SHALL, in DONE, assert done for exactly one cycle and then go to IDLE; checksum holds until the next accepted start.
REQ-026 SHALL ignore start outside IDLE, and SHALL ignore pix_valid outside COLLECT (no transfer occurs).
REQ-027 SHALL wrap byte_cnt modulo 2^LEN_W; msg_len=2^LEN_W-1 is the maximum message length.
REQ-028 SHALL allow a new start in the cycle immediately after DONE.

Reset
REQ-029 SHALL, on wb_rst_n=0 at any time including mid-message, immediately force IDLE, pix_ready=0, msg_valid=0, msg_byte=0, busy=0, done=0, checksum=0, and clear all counters, the shift register and key_cur.
REQ-030 SHALL discard a partial byte on reset; no byte is emitted after release until a new start.

Structure
REQ-031 SHALL place the FSM state enum, PIX_W/LEN_W defaults and BITS_PER_BYTE=8 in shared package lsb_pkg.
REQ-032 SHALL place the key register (load, rotate-left, XOR) in sub-module lsb_keystream.

Verification
REQ-033 SHALL check: key=0xA5, len=1, pixel LSBs 1,0,1,0,0,1,0,1 -> msg_byte=0x00 one cycle after the 8th pixel, done pulse, checksum=0x00.
REQ-034 SHALL check: key=0xA5, len=2, LSB bytes 0xA5 then 0x4B -> bytes 0x00, 0x00, with the second byte using key_cur=0x4B.
REQ-035 SHALL check: msg_ready held 0 for 5 cycles in EMIT -> msg_byte stable, pix_ready=0, no pixel consumed.
REQ-036 SHALL check: start with msg_len=0 -> busy for exactly 1 cycle, done pulse, no msg_valid.
REQ-037 SHALL check: wb_rst_n low after 4 pixels -> all outputs 0; a new start with key=0x00 and LSBs 0xFF -> msg_byte=0xFF.
REQ-038 SHALL check: start pulsed during COLLECT -> ignored; msg_len and key remain at their first-latched values.

Source files
------------

// File: rtl/lsb_pkg.sv
// Shared types and defaults for the LSB steganography extractor.
// Holds the FSM state encoding and the width defaults used by the top.
package lsb_pkg;

  localparam int DEF_PIX_W     = 8;
  localparam int DEF_LEN_W     = 8;
  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/lsb_keystream.sv
// Decryption key register: loads on start, rotates left after each byte; XOR is combinational.
// Zero-latency XOR path, no backpressure of its own (the caller decides when to rotate).
module lsb_keystream
  import lsb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [BITS_PER_BYTE-1:0] key_in,
  input  logic                     rotate,
  input  logic [BITS_PER_BYTE-1:0] data_in,
  output logic [BITS_PER_BYTE-1:0] key_cur,
  output logic [BITS_PER_BYTE-1:0] data_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_cur <= '0;
    end else if (load) begin
      key_cur <= key_in;
    end else if (rotate) begin
      key_cur <= {key_cur[BITS_PER_BYTE-2:0], key_cur[BITS_PER_BYTE-1]};
    end
  end

  assign data_out = data_in ^ key_cur;

endmodule

// File: rtl/lsb_extract.sv
// Rebuilds message bytes from pixel LSBs (MSB-first), decrypts with a rotating key, tracks XOR checksum.
// Byte valid one cycle after its 8th pixel; a stalled msg_ready holds the byte and blocks pixel intake.
module lsb_extract
  import lsb_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             wb_clk,
  input  logic             wb_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [7:0]       key,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [7:0]       msg_byte,
  output logic             msg_valid,
  input  logic             msg_ready,
  output logic             busy,
  output logic             done,
  output logic [7:0]       checksum
);

  state_t                   state;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         byte_cnt;
  logic [LEN_W-1:0]         byte_cnt_nxt;
  logic [2:0]               bit_cnt;
  logic [BITS_PER_BYTE-1:0] shreg;
  logic [BITS_PER_BYTE-1:0] assembled;
  logic [BITS_PER_BYTE-1:0] key_cur;
  logic [BITS_PER_BYTE-1:0] dec_byte;
  logic                     start_acc;
  logic                     msg_hs;
  logic                     unused_pix;

  // Only the LSB of each sample carries payload.
  assign unused_pix   = ^pix_data;

  assign start_acc    = (state == ST_IDLE) && start;
  assign msg_hs       = msg_valid && msg_ready;
  assign assembled    = {shreg[BITS_PER_BYTE-2:0], pix_data[0]};
  assign byte_cnt_nxt = byte_cnt + 1'b1;

  assign pix_ready    = (state == ST_COLLECT);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

  lsb_keystream u_keystream (
    .clk      (wb_clk),
    .rst_n    (wb_rst_n),
    .load     (start_acc),
    .key_in   (key),
    .rotate   (msg_hs),
    .data_in  (assembled),
    .key_cur  (key_cur),
    .data_out (dec_byte)
  );

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      msg_byte  <= '0;
      msg_valid <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q    <= msg_len;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            checksum <= '0;
            state    <= (msg_len == '0) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (pix_valid) begin
            shreg   <= assembled;
            bit_cnt <= bit_cnt + 3'd1;
            // Eighth bit completes the byte; decrypt with the key as it stands now.
            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
              msg_byte  <= dec_byte;
              msg_valid <= 1'b1;
              state     <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (msg_ready) begin
            msg_valid <= 1'b0;
            checksum  <= checksum ^ msg_byte;
            byte_cnt  <= byte_cnt_nxt;
            state     <= (byte_cnt_nxt == len_q) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_extract.sv
// Directed self-checking bench for lsb_extract; inputs driven and outputs sampled on the falling edge.
module tb_lsb_extract;

  localparam int PIX_W = 8;
  localparam int LEN_W = 8;

  logic             wb_clk = 1'b0;
  logic             wb_rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic [7:0]       key = '0;
  logic [PIX_W-1:0] pix_data = '0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [7:0]       msg_byte;
  logic             msg_valid;
  logic             msg_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [7:0]       checksum;

  int total = 0;
  int bad   = 0;

  lsb_extract #(.PIX_W(PIX_W), .LEN_W(LEN_W)) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .start     (start),
    .msg_len   (msg_len),
    .key       (key),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .msg_byte  (msg_byte),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [LEN_W-1:0] len, input logic [7:0] k);
    @(negedge wb_clk);
    start   = 1'b1;
    msg_len = len;
    key     = k;
    @(negedge wb_clk);
    start   = 1'b0;
  endtask

  // Push bits b[hi] down to b[lo]; upper pixel bits are set to 1 to prove only bit 0 matters.
  task automatic push_bits(input logic [7:0] b, input int hi, input int lo);
    int n;
    for (int i = hi; i >= lo; i--) begin
      pix_valid = 1'b1;
      pix_data  = {{(PIX_W-1){1'b1}}, b[i]};
      n = 0;
      while (!pix_ready && n < 50) begin
        @(negedge wb_clk);
        n++;
      end
      if (n >= 50) begin
        total++;
        bad++;
        $display("FAIL push_timeout: pix_ready=%0b required 1 within 50 cycles", pix_ready);
      end
      @(negedge wb_clk);
    end
    pix_valid = 1'b0;
  endtask

  task automatic accept();
    msg_ready = 1'b1;
    @(negedge wb_clk);
    msg_ready = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_n = 1'b0;
    @(negedge wb_clk);
    total++;
    if ({pix_ready, msg_valid, busy, done, msg_byte, checksum} !== 20'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 00000",
               {pix_ready, msg_valid, busy, done, msg_byte, checksum});
    end
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
  endtask

  task automatic test_single();
    do_start(8'd1, 8'hA5);
    push_bits(8'hA5, 7, 0);
    total++;
    if (msg_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_valid_latency: got %0b required 1", msg_valid);
    end
    total++;
    if (msg_byte !== 8'h00) begin
      bad++;
      $display("FAIL single_byte: got %h required 00", msg_byte);
    end
    accept();
    total++;
    if ({done, msg_valid} !== 2'b10) begin
      bad++;
      $display("FAIL single_done: got done,valid=%b required 10", {done, msg_valid});
    end
    total++;
    if (checksum !== 8'h00) begin
      bad++;
      $display("FAIL single_checksum: got %h required 00", checksum);
    end
  endtask

  // Starts in the IDLE cycle right after DONE; second byte uses rotated key 0x4B.
  task automatic test_back_to_back();
    do_start(8'd2, 8'hA5);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start_accepted: busy=%0b required 1", busy);
    end
    push_bits(8'hA5, 7, 0);
    total++;
    if ({msg_valid, msg_byte} !== 9'h100) begin
      bad++;
      $display("FAIL b2b_byte0: got valid,byte=%h required 100", {msg_valid, msg_byte});
    end
    accept();
    total++;
    if ({done, pix_ready} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_mid_state: got done,pix_ready=%b required 01", {done, pix_ready});
    end
    push_bits(8'h4B, 7, 0);
    total++;
    if ({msg_valid, msg_byte} !== 9'h100) begin
      bad++;
      $display("FAIL b2b_byte1: got valid,byte=%h required 100", {msg_valid, msg_byte});
    end
    accept();
    total++;
    if ({done, checksum} !== 9'h100) begin
      bad++;
      $display("FAIL b2b_done_checksum: got done,checksum=%h required 100", {done, checksum});
    end
  endtask

  // key 0x0F: 0x12^0x0F=0x1D, key->0x1E, 0x34^0x1E=0x2A, checksum 0x37.
  task automatic test_checksum();
    do_start(8'd2, 8'h0F);
    push_bits(8'h12, 7, 0);
    total++;
    if (msg_byte !== 8'h1D) begin
      bad++;
      $display("FAIL cks_byte0: got %h required 1d", msg_byte);
    end
    accept();
    push_bits(8'h34, 7, 0);
    total++;
    if (msg_byte !== 8'h2A) begin
      bad++;
      $display("FAIL cks_byte1: got %h required 2a", msg_byte);
    end
    accept();
    @(negedge wb_clk);
    total++;
    if ({busy, done, checksum} !== 10'h037) begin
      bad++;
      $display("FAIL cks_hold: got busy,done,checksum=%h required 037", {busy, done, checksum});
    end
  endtask

  task automatic test_stall();
    do_start(8'd2, 8'h00);
    push_bits(8'h5A, 7, 0);
    pix_valid = 1'b1;
    pix_data  = '1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({msg_valid, pix_ready, msg_byte} !== 10'h25A) begin
        bad++;
        $display("FAIL stall_hold_%0d: got valid,pix_ready,byte=%h required 25a",
                 k, {msg_valid, pix_ready, msg_byte});
      end
      @(negedge wb_clk);
    end
    pix_valid = 1'b0;
    accept();
    push_bits(8'h00, 7, 0);
    total++;
    if ({msg_valid, msg_byte} !== 9'h100) begin
      bad++;
      $display("FAIL stall_no_consume: got valid,byte=%h required 100", {msg_valid, msg_byte});
    end
    accept();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL stall_done: got %0b required 1", done);
    end
  endtask

  task automatic test_zero_len();
    do_start(8'd0, 8'h11);
    total++;
    if ({busy, done, msg_valid, pix_ready} !== 4'b1100) begin
      bad++;
      $display("FAIL zero_len_pulse: got busy,done,valid,pix_ready=%b required 1100",
               {busy, done, msg_valid, pix_ready});
    end
    @(negedge wb_clk);
    total++;
    if ({busy, done, msg_valid} !== 3'b000) begin
      bad++;
      $display("FAIL zero_len_after: got busy,done,valid=%b required 000", {busy, done, msg_valid});
    end
  endtask

  task automatic test_reset_mid();
    do_start(8'd1, 8'h77);
    push_bits(8'hF0, 7, 4);
    wb_rst_n = 1'b0;
    #1;
    total++;
    if ({pix_ready, msg_valid, busy, done, msg_byte, checksum} !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got %h required 00000",
               {pix_ready, msg_valid, busy, done, msg_byte, checksum});
    end
    @(negedge wb_clk);
    wb_rst_n  = 1'b1;
    pix_valid = 1'b1;
    repeat (3) @(negedge wb_clk);
    total++;
    if ({msg_valid, pix_ready, busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid_quiet: got valid,pix_ready,busy=%b required 000",
               {msg_valid, pix_ready, busy});
    end
    pix_valid = 1'b0;
    do_start(8'd1, 8'h00);
    push_bits(8'hFF, 7, 0);
    total++;
    if ({msg_valid, msg_byte} !== 9'h1FF) begin
      bad++;
      $display("FAIL reset_mid_newbyte: got valid,byte=%h required 1ff", {msg_valid, msg_byte});
    end
    accept();
    total++;
    if ({done, checksum} !== 9'h1FF) begin
      bad++;
      $display("FAIL reset_mid_checksum: got done,checksum=%h required 1ff", {done, checksum});
    end
  endtask

  task automatic test_start_ignored();
    do_start(8'd1, 8'hA5);
    push_bits(8'hA5, 7, 5);
    start   = 1'b1;
    msg_len = 8'd5;
    key     = 8'h3C;
    @(negedge wb_clk);
    start   = 1'b0;
    push_bits(8'hA5, 4, 0);
    total++;
    if ({msg_valid, msg_byte} !== 9'h100) begin
      bad++;
      $display("FAIL ignore_start_key: got valid,byte=%h required 100", {msg_valid, msg_byte});
    end
    accept();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL ignore_start_len: done=%0b required 1", done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_checksum();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_start_ignored();
    repeat (2) @(negedge wb_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
